gb_cpu_irq_dispatch: RTL and testbench

Interrupt dispatch sequencer for the Game Boy CPU core. At an instruction boundary it samples pending interrupts (IE & IF), arbitrates by fixed priority and takes over the register file's IDU write port. It then runs the 5 M-cycle service sequence: decrement SP, push PC, load the vector, clear IME and acknowledge the IF bit. It sits between the control unit, interrupt registers, memory bus and gb_cpu_regfile.

---
 rtl/gb_cpu_common_pkg.sv | 31 +++
 rtl/gb_cpu_irq_dispatch_prio_enc.sv | 12 +
 rtl/gb_cpu_irq_dispatch.sv | 114 +++++++++++
 tb/tb_gb_cpu_irq_dispatch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gb_cpu_common_pkg.sv
// gb_cpu_common_pkg: shared CPU core types, plus interrupt dispatch states,
// source indices, the vector helper and the fixed-priority encoder helper.
package gb_cpu_common_pkg;
   typedef enum logic [2:0] {R16_BC, R16_DE, R16_HL, R16_SP, R16_PC, R16_AF} regfile_r16_t;
   typedef enum logic [2:0] {IDLE, D1, D2, D3, D4, D5} irq_state_t;
   localparam int IRQ_VBLANK = 0;
   localparam int IRQ_LCD    = 1;
   localparam int IRQ_TIMER  = 2;
   localparam int IRQ_SERIAL = 3;
   localparam int IRQ_JOYPAD = 4;
   localparam int IRQ_MAX    = 8;
   localparam logic [15:0] IRQ_VECTOR_BASE   = 16'h0040;
   localparam logic [15:0] IRQ_VECTOR_STRIDE = 16'd8;
   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } irq_prio_t;
   function automatic logic [15:0] getIrqVector(input logic [2:0] idx,
                                                input logic [15:0] base = IRQ_VECTOR_BASE,
                                                input logic [15:0] stride = IRQ_VECTOR_STRIDE);
      return base + stride * {13'd0, idx};
   endfunction
   // Scan from the top down so the lowest set bit is the one left standing.
   function automatic irq_prio_t prioEncode(input logic [IRQ_MAX-1:0] pending);
      irq_prio_t r;
      r = '0;
      for (int i = IRQ_MAX - 1; i >= 0; i--)
         if (pending[i]) r = '{valid: 1'b1, idx: 3'(i)};
      return r;
   endfunction
endpackage

// File: rtl/gb_cpu_irq_dispatch_prio_enc.sv
// gb_cpu_irq_prio_enc: fixed-priority encoder, bit 0 highest, up to IRQ_MAX sources.
module gb_cpu_irq_prio_enc
   import gb_cpu_common_pkg::*;
#(
   parameter int NUM_IRQ = 5
) (
   input  logic [NUM_IRQ-1:0] pending,
   output logic               valid,
   output logic [2:0]         idx
);
   assign {valid, idx} = prioEncode(IRQ_MAX'(pending));
endmodule

// File: rtl/gb_cpu_irq_dispatch.sv
// gb_cpu_irq_dispatch: 5 M-cycle interrupt service sequencer (SP push, vector load, IF ack).
// Build option GB_CPU_IRQ_CANCEL_EN: resample pending in D4 and vector to 0000 if it vanished.
module gb_cpu_irq_dispatch
   import gb_cpu_common_pkg::*;
#(
   parameter int          NUM_IRQ       = 5,
   parameter logic [15:0] VECTOR_BASE   = 16'h0040,
   parameter logic [15:0] VECTOR_STRIDE = 16'd8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ime,
   input  logic [NUM_IRQ-1:0] int_enable,
   input  logic [NUM_IRQ-1:0] int_flag,
   input  logic               instr_boundary,
   input  logic               halted,
   input  logic [15:0]        sp,
   input  logic [15:0]        pc,
   output logic               busy,
   output regfile_r16_t       idu_req,
   output logic [15:0]        idu_data,
   output logic               idu_wren,
   output logic [15:0]        mem_addr,
   output logic [7:0]         mem_wdata,
   output logic               mem_wren,
   output logic               ime_clear,
   output logic [NUM_IRQ-1:0] irq_ack,
   output logic               halt_exit
);
   logic               pend_valid;
   logic [2:0]         pend_idx;
   logic               enter;
   logic [2:0]         sel_idx;
   logic               sel_ok;
   irq_state_t         state_q, state_d;
   regfile_r16_t       idu_req_q, idu_req_d;
   logic [15:0]        idu_data_q, idu_data_d, mem_addr_q, mem_addr_d;
   logic [7:0]         mem_wdata_q, mem_wdata_d;
   logic               idu_wren_q, idu_wren_d, mem_wren_q, mem_wren_d;
   logic               ime_clear_q, ime_clear_d, halt_exit_q, halt_exit_d;
   logic [NUM_IRQ-1:0] irq_ack_q, irq_ack_d;

   gb_cpu_irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
      .pending (int_enable & int_flag),
      .valid   (pend_valid),
      .idx     (pend_idx)
   );

   assign enter = (state_q == IDLE) & ime & pend_valid & (instr_boundary | halted);

`ifdef GB_CPU_IRQ_CANCEL_EN
   // Outputs for D5 are registered on the D4->D5 edge, so the live encoder is the D4 sample.
   assign sel_idx = pend_idx;
   assign sel_ok  = pend_valid;
`else
   logic [2:0] idx_q, idx_d;
   assign idx_d   = enter ? pend_idx : idx_q;
   assign sel_idx = idx_q;
   assign sel_ok  = 1'b1;
   always_ff @(posedge clk) idx_q <= reset ? 3'd0 : idx_d;
`endif

   always_comb begin
      state_d     = state_q == IDLE ? (enter ? D1 : IDLE) :
                    state_q == D5   ? IDLE : irq_state_t'(state_q + 3'd1);
      idu_wren_d  = state_d == D2 || state_d == D3 || state_d == D5;
      idu_req_d   = state_d == D5 ? R16_PC : R16_SP;
      idu_data_d  = state_d == D5 ? (sel_ok ? getIrqVector(sel_idx, VECTOR_BASE, VECTOR_STRIDE) : 16'h0000) :
                    idu_wren_d    ? sp - 16'd1 : 16'h0000;
      mem_wren_d  = state_d == D3 || state_d == D4;
      mem_addr_d  = mem_wren_d ? sp : 16'h0000;
      mem_wdata_d = state_d == D3 ? pc[15:8] : state_d == D4 ? pc[7:0] : 8'h00;
      ime_clear_d = state_d == D1;
      irq_ack_d   = (state_d == D5 && sel_ok) ? NUM_IRQ'(1) << sel_idx : '0;
      halt_exit_d = (state_q == IDLE) & halted & pend_valid;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idu_req_q   <= R16_SP;
         idu_data_q  <= '0;
         idu_wren_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wren_q  <= 1'b0;
         ime_clear_q <= 1'b0;
         irq_ack_q   <= '0;
         halt_exit_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idu_req_q   <= idu_req_d;
         idu_data_q  <= idu_data_d;
         idu_wren_q  <= idu_wren_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wren_q  <= mem_wren_d;
         ime_clear_q <= ime_clear_d;
         irq_ack_q   <= irq_ack_d;
         halt_exit_q <= halt_exit_d;
      end
   end

   assign busy      = state_q != IDLE;
   assign idu_req   = idu_req_q;
   assign idu_data  = idu_data_q;
   assign idu_wren  = idu_wren_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wren  = mem_wren_q;
   assign ime_clear = ime_clear_q;
   assign irq_ack   = irq_ack_q;
   assign halt_exit = halt_exit_q;
endmodule

// File: tb/tb_gb_cpu_irq_dispatch.sv
// tb_gb_cpu_irq_dispatch: randomized bench with a regfile/IME/IF environment and a spec-level model.
module tb_gb_cpu_irq_dispatch;
   import gb_cpu_common_pkg::*;

   logic         clk, reset, ime, instr_boundary, halted;
   logic [4:0]   int_enable, int_flag;
   logic [15:0]  sp_r, pc_r;
   logic         busy, idu_wren, mem_wren, ime_clear, halt_exit;
   regfile_r16_t idu_req;
   logic [15:0]  idu_data, mem_addr;
   logic [7:0]   mem_wdata;
   logic [4:0]   irq_ack;

   int           total, bad;
   int           n_busy, n_clr, n_halt, n_ack;
   logic [4:0]   ack_or;
   logic [15:0]  wr_a[$];
   logic [7:0]   wr_d[$];
   logic [50:0]  snap;

   gb_cpu_irq_dispatch dut (
      .clk(clk), .reset(reset), .ime(ime), .int_enable(int_enable), .int_flag(int_flag),
      .instr_boundary(instr_boundary), .halted(halted), .sp(sp_r), .pc(pc_r),
      .busy(busy), .idu_req(idu_req), .idu_data(idu_data), .idu_wren(idu_wren),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
      .ime_clear(ime_clear), .irq_ack(irq_ack), .halt_exit(halt_exit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lowest(input logic [4:0] p);
      for (int i = 0; i < 5; i++) if (p[i]) return i;
      return -1;
   endfunction

   function automatic logic [15:0] vec_of(input int i);
      return i < 0 ? 16'h0000 : 16'h0040 + 16'(8 * i);
   endfunction

   // One M-cycle: observe outputs and play the regfile / IME / IF / HALT roles at negedge.
   task automatic tick();
      @(negedge clk);
      n_busy += int'(busy);
      n_clr  += int'(ime_clear);
      n_halt += int'(halt_exit);
      n_ack  += int'(irq_ack != 5'd0);
      ack_or |= irq_ack;
      if (mem_wren) begin
         wr_a.push_back(mem_addr);
         wr_d.push_back(mem_wdata);
      end
      if (idu_wren && idu_req == R16_SP) sp_r = idu_data;
      if (idu_wren && idu_req == R16_PC) pc_r = idu_data;
      if (ime_clear) ime = 1'b0;
      int_flag &= ~irq_ack;
      if (halt_exit) halted = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] sp0, input logic [15:0] pc0, input logic [4:0] ie0,
                        input logic [4:0] if0, input logic hlt, input logic ime0,
                        input int clr_at, input int rst_at);
      sp_r = sp0; pc_r = pc0; int_enable = ie0; int_flag = if0;
      halted = hlt; ime = ime0; instr_boundary = !hlt;
      n_busy = 0; n_clr = 0; n_halt = 0; n_ack = 0; ack_or = '0; snap = '1;
      wr_a.delete(); wr_d.delete();
      for (int t = 1; t <= 14; t++) begin
         tick();
         if (t == rst_at + 1) begin
            snap = {busy, idu_wren, idu_req != R16_SP, idu_data, mem_addr, mem_wdata,
                    mem_wren, ime_clear, irq_ack, halt_exit};
            reset = 1'b0;
         end
         if (t == rst_at) reset = 1'b1;
         if (t == clr_at) int_enable = '0;
         instr_boundary = 1'($urandom);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (idu_req !== R16_SP) begin bad++; $display("FAIL reset_idu_req got=%0d exp=%0d", idu_req, R16_SP); end
      total++; if ({idu_wren, mem_wren} !== 2'b00) begin bad++; $display("FAIL reset_wren got=%b exp=00", {idu_wren, mem_wren}); end
      total++; if ({idu_data, mem_addr, mem_wdata} !== 40'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", {idu_data, mem_addr, mem_wdata}); end
      total++; if ({ime_clear, irq_ack, halt_exit} !== 7'd0) begin bad++; $display("FAIL reset_pulses got=%b exp=0", {ime_clear, irq_ack, halt_exit}); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      drive(16'hFFFE, 16'h1234, 5'h1F, 5'h04, 1'b0, 1'b1, -1, -1);
      total++; if (n_busy != 5) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=5", n_busy); end
      total++; if (wr_a.size() != 2) begin bad++; $display("FAIL basic_nwrites got=%0d exp=2", wr_a.size()); end
      else begin
         total++; if ({wr_a[0], wr_d[0]} !== 24'hFFFD12) begin bad++; $display("FAIL basic_push_hi got=%h exp=FFFD12", {wr_a[0], wr_d[0]}); end
         total++; if ({wr_a[1], wr_d[1]} !== 24'hFFFC34) begin bad++; $display("FAIL basic_push_lo got=%h exp=FFFC34", {wr_a[1], wr_d[1]}); end
      end
      total++; if (sp_r !== 16'hFFFC) begin bad++; $display("FAIL basic_sp got=%h exp=FFFC", sp_r); end
      total++; if (pc_r !== 16'h0050) begin bad++; $display("FAIL basic_pc got=%h exp=0050", pc_r); end
      total++; if (ack_or !== 5'h04 || n_ack != 1) begin bad++; $display("FAIL basic_ack got=%h/%0d exp=04/1", ack_or, n_ack); end
      total++; if (n_clr != 1) begin bad++; $display("FAIL basic_ime_clear got=%0d exp=1", n_clr); end
   endtask

   task automatic test_priority();
      drive(16'hC000, 16'h0200, 5'h1F, 5'h06, 1'b0, 1'b1, -1, -1);
      total++; if (pc_r !== 16'h0048) begin bad++; $display("FAIL prio_pc got=%h exp=0048", pc_r); end
      total++; if (ack_or !== 5'h02) begin bad++; $display("FAIL prio_ack got=%h exp=02", ack_or); end
      total++; if (int_flag !== 5'h04) begin bad++; $display("FAIL prio_if_left got=%h exp=04", int_flag); end
   endtask

   task automatic test_halt();
      drive(16'hD000, 16'h0300, 5'h01, 5'h01, 1'b1, 1'b0, -1, -1);
      total++; if (n_halt != 1) begin bad++; $display("FAIL halt_noime_exit got=%0d exp=1", n_halt); end
      total++; if (n_busy != 0 || wr_a.size() != 0) begin bad++; $display("FAIL halt_noime_dispatch got=%0d/%0d exp=0/0", n_busy, wr_a.size()); end
      drive(16'hD000, 16'h0300, 5'h01, 5'h01, 1'b1, 1'b1, -1, -1);
      total++; if (n_halt != 1) begin bad++; $display("FAIL halt_ime_exit got=%0d exp=1", n_halt); end
      total++; if (n_busy != 5 || pc_r !== 16'h0040) begin bad++; $display("FAIL halt_ime_dispatch got=%0d/%h exp=5/0040", n_busy, pc_r); end
   endtask

   task automatic test_sp_wrap();
      drive(16'h0000, 16'hABCD, 5'h10, 5'h10, 1'b0, 1'b1, -1, -1);
      total++; if (wr_a.size() != 2) begin bad++; $display("FAIL wrap_nwrites got=%0d exp=2", wr_a.size()); end
      else begin
         total++; if ({wr_a[0], wr_a[1]} !== 32'hFFFFFFFE) begin bad++; $display("FAIL wrap_addrs got=%h exp=FFFFFFFE", {wr_a[0], wr_a[1]}); end
      end
      total++; if (sp_r !== 16'hFFFE || pc_r !== 16'h0060) begin bad++; $display("FAIL wrap_sp_pc got=%h/%h exp=FFFE/0060", sp_r, pc_r); end
   endtask

   task automatic test_cancel();
      logic [15:0] pc_exp;
      logic [4:0]  ack_exp;
`ifdef GB_CPU_IRQ_CANCEL_EN
      pc_exp = 16'h0000; ack_exp = 5'h00;
`else
      pc_exp = 16'h0040; ack_exp = 5'h01;
`endif
      drive(16'hDFF0, 16'h4567, 5'h1F, 5'h01, 1'b0, 1'b1, 3, -1);
      total++; if (pc_r !== pc_exp) begin bad++; $display("FAIL cancel_pc got=%h exp=%h", pc_r, pc_exp); end
      total++; if (ack_or !== ack_exp) begin bad++; $display("FAIL cancel_ack got=%h exp=%h", ack_or, ack_exp); end
      total++; if (wr_a.size() != 2 || sp_r !== 16'hDFEE) begin bad++; $display("FAIL cancel_push got=%0d/%h exp=2/DFEE", wr_a.size(), sp_r); end
   endtask

   task automatic test_reset_mid();
      drive(16'hE000, 16'h789A, 5'h1F, 5'h08, 1'b0, 1'b1, -1, 3);
      total++; if (snap !== 51'd0) begin bad++; $display("FAIL rstmid_outputs got=%h exp=0", snap); end
      total++; if (wr_a.size() != 1) begin bad++; $display("FAIL rstmid_nwrites got=%0d exp=1", wr_a.size()); end
      total++; if (ack_or !== 5'h00 || pc_r !== 16'h789A) begin bad++; $display("FAIL rstmid_no_d5 got=%h/%h exp=00/789A", ack_or, pc_r); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      drive(16'hFF00, 16'h0150, 5'h1F, 5'h03, 1'b0, 1'b1, -1, -1);
      total++; if (n_busy != 5 || ack_or !== 5'h01) begin bad++; $display("FAIL b2b_first got=%0d/%h exp=5/01", n_busy, ack_or); end
      total++; if (int_flag !== 5'h02) begin bad++; $display("FAIL b2b_if_left got=%h exp=02", int_flag); end
      drive(sp_r, pc_r, 5'h1F, int_flag, 1'b0, 1'b1, -1, -1);
      total++; if (pc_r !== 16'h0048 || ack_or !== 5'h02) begin bad++; $display("FAIL b2b_second got=%h/%h exp=0048/02", pc_r, ack_or); end
      total++; if (sp_r !== 16'hFEFC) begin bad++; $display("FAIL b2b_sp got=%h exp=FEFC", sp_r); end
      total++; if (wr_a.size() != 2 || {wr_d[0], wr_d[1]} !== 16'h0040) begin bad++; $display("FAIL b2b_pushed_pc got=%0d exp=0040", wr_a.size()); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 20; n++) begin
         logic [15:0] sp0, pc0;
         logic [4:0]  ie0, if0, ack_exp;
         logic        hlt;
         int          sel;
         sp0 = 16'($urandom); pc0 = 16'($urandom);
         ie0 = 5'($urandom_range(1, 31)); if0 = 5'($urandom_range(0, 31));
         if ((ie0 & if0) == 5'd0) if0 |= ie0;
         hlt = 1'($urandom);
         sel = lowest(ie0 & if0);
         ack_exp = 5'(1 << sel);
         drive(sp0, pc0, ie0, if0, hlt, 1'b1, -1, -1);
         total++; if (n_busy != 5 || n_clr != 1 || n_halt != int'(hlt)) begin bad++; $display("FAIL rnd%0d_counts got=%0d/%0d/%0d exp=5/1/%0d", n, n_busy, n_clr, n_halt, hlt); end
         total++; if (wr_a.size() != 2) begin bad++; $display("FAIL rnd%0d_nwrites got=%0d exp=2", n, wr_a.size()); end
         else begin
            total++; if ({wr_a[0], wr_d[0], wr_a[1], wr_d[1]} !== {sp0 - 16'd1, pc0[15:8], sp0 - 16'd2, pc0[7:0]})
               begin bad++; $display("FAIL rnd%0d_pushes got=%h exp=%h", n, {wr_a[0], wr_d[0], wr_a[1], wr_d[1]}, {sp0 - 16'd1, pc0[15:8], sp0 - 16'd2, pc0[7:0]}); end
         end
         total++; if (sp_r !== sp0 - 16'd2 || pc_r !== vec_of(sel)) begin bad++; $display("FAIL rnd%0d_sp_pc got=%h/%h exp=%h/%h", n, sp_r, pc_r, sp0 - 16'd2, vec_of(sel)); end
         total++; if (ack_or !== ack_exp || n_ack != 1 || int_flag !== (if0 & ~ack_exp)) begin bad++; $display("FAIL rnd%0d_ack got=%h/%0d/%h exp=%h/1/%h", n, ack_or, n_ack, int_flag, ack_exp, if0 & ~ack_exp); end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      reset = 1'b1; ime = 1'b0; instr_boundary = 1'b0; halted = 1'b0;
      int_enable = '0; int_flag = '0; sp_r = '0; pc_r = '0;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_priority();
      test_halt();
      test_sp_wrap();
      test_cancel();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
